// File: rtl/pisca_decoder_if.sv
// Signal bundle between the LED chaser pattern source and the pisca_decoder.
// The slave side is the decoder. The master side drives samples and observes the classification.
interface pisca_decoder_if;
  logic [7:0] pattern_in;
  logic [2:0] pos;
  logic       valid;
  logic       dir;
  logic       frozen;
  logic       restart_evt;
  logic [7:0] lap_count;
  logic       error;
  logic       error_sticky;
  logic [7:0] SEG;

  modport master (
    output pattern_in,
    input  pos, valid, dir, frozen, restart_evt, lap_count, error, error_sticky, SEG
  );

  modport slave (
    input  pattern_in,
    output pos, valid, dir, frozen, restart_evt, lap_count, error, error_sticky, SEG
  );
endinterface

// File: rtl/pisca_decoder.sv
// Classifies each LED chaser sample against the previous one (one-cycle latency).
// Reports position, direction, freeze, restarts, errors, completed laps and a 7-segment digit.
module pisca_decoder (
  input  logic           clk_2,
  input  logic           reset,
  pisca_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_ERR} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_prev;
  logic [2:0] r_pos, w_pos_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_dir, w_dir_nxt;
  logic       r_frozen, w_frozen_nxt;
  logic       r_restart, w_restart_nxt;
  logic [7:0] r_lap, w_lap_nxt;
  logic       r_error, w_error_nxt;
  logic       r_sticky;
  logic [7:0] r_seg, w_seg_nxt;

  logic [7:0] w_c;
  logic [2:0] w_c_idx;
  logic       w_onehot, w_same, w_right, w_left, w_gap_ok, w_end_in;

  function automatic logic [2:0] f_index(input logic [7:0] v);
    f_index = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) f_index = 3'(i);
  endfunction

  function automatic logic [6:0] f_digit(input logic [2:0] d);
    case (d)
      3'd0:    f_digit = 7'h3F;
      3'd1:    f_digit = 7'h06;
      3'd2:    f_digit = 7'h5B;
      3'd3:    f_digit = 7'h4F;
      3'd4:    f_digit = 7'h66;
      3'd5:    f_digit = 7'h6D;
      3'd6:    f_digit = 7'h7D;
      default: f_digit = 7'h07;
    endcase
  endfunction

  // The guards on the shifts stop 0x01>>1 and 0x80<<1 from matching an all-dark sample.
  assign w_c      = bus.pattern_in;
  assign w_c_idx  = f_index(w_c);
  assign w_onehot = (w_c != 8'h00) && ((w_c & (w_c - 8'd1)) == 8'h00);
  assign w_same   = (w_c == r_prev);
  assign w_right  = (r_prev != 8'h01) && (w_c == (r_prev >> 1));
  assign w_left   = (r_prev != 8'h80) && (w_c == (r_prev << 1));
  assign w_gap_ok = (w_c == 8'h00) && ((r_prev == 8'h01) || (r_prev == 8'h80));
  assign w_end_in = (w_c == 8'h80) || (w_c == 8'h01);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_prev    <= 8'h00;
      r_pos     <= 3'd0;
      r_valid   <= 1'b0;
      r_dir     <= 1'b0;
      r_frozen  <= 1'b0;
      r_restart <= 1'b0;
      r_lap     <= 8'h00;
      r_error   <= 1'b0;
      r_sticky  <= 1'b0;
      r_seg     <= 8'h40;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_c;
      r_pos     <= w_pos_nxt;
      r_valid   <= w_valid_nxt;
      r_dir     <= w_dir_nxt;
      r_frozen  <= w_frozen_nxt;
      r_restart <= w_restart_nxt;
      r_lap     <= w_lap_nxt;
      r_error   <= w_error_nxt;
      r_sticky  <= r_sticky | w_error_nxt;
      r_seg     <= w_seg_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (w_onehot)             w_state_nxt = S_RUN;
        else if (w_c != 8'h00)    w_state_nxt = S_ERR;
      end
      S_RUN: begin
        if (w_same || w_right || w_left) w_state_nxt = S_RUN;
        else if (w_gap_ok)               w_state_nxt = S_GAP;
        else if (w_end_in)               w_state_nxt = S_RUN;
        else                             w_state_nxt = S_ERR;
      end
      S_GAP: begin
        if (w_end_in)             w_state_nxt = S_RUN;
        else if (w_c != 8'h00)    w_state_nxt = S_ERR;
      end
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pos_nxt     = r_pos;
    w_valid_nxt   = 1'b0;
    w_dir_nxt     = r_dir;
    w_frozen_nxt  = 1'b0;
    w_restart_nxt = 1'b0;
    w_lap_nxt     = r_lap;
    w_error_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (w_onehot) begin
          w_valid_nxt = 1'b1;
          w_pos_nxt   = w_c_idx;
        end else if (w_c != 8'h00) begin
          w_error_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_same) begin
          w_valid_nxt  = 1'b1;
          w_frozen_nxt = 1'b1;
          w_pos_nxt    = w_c_idx;
        end else if (w_right || w_left) begin
          w_valid_nxt = 1'b1;
          w_pos_nxt   = w_c_idx;
          w_dir_nxt   = w_left;
        end else if (w_gap_ok) begin
          w_valid_nxt = 1'b0;
        end else if (w_end_in) begin
          w_valid_nxt   = 1'b1;
          w_pos_nxt     = w_c_idx;
          w_restart_nxt = 1'b1;
          w_dir_nxt     = (w_c == 8'h01);
        end else begin
          w_error_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (w_end_in) begin
          w_valid_nxt = 1'b1;
          w_pos_nxt   = w_c_idx;
          w_dir_nxt   = (w_c == 8'h01);
          w_lap_nxt   = r_lap + 8'd1;
        end else if (w_c != 8'h00) begin
          w_error_nxt = 1'b1;
        end
      end
      default: w_valid_nxt = 1'b0;
    endcase

    if (w_valid_nxt)                w_seg_nxt = {w_frozen_nxt, f_digit(w_pos_nxt)};
    else if (w_state_nxt == S_ERR)  w_seg_nxt = {w_frozen_nxt, 7'h79};
    else                            w_seg_nxt = {w_frozen_nxt, 7'h40};
  end

  assign bus.pos          = r_pos;
  assign bus.valid        = r_valid;
  assign bus.dir          = r_dir;
  assign bus.frozen       = r_frozen;
  assign bus.restart_evt  = r_restart;
  assign bus.lap_count    = r_lap;
  assign bus.error        = r_error;
  assign bus.error_sticky = r_sticky;
  assign bus.SEG          = r_seg;

endmodule

// File: tb/tb_pisca_decoder.sv
// Scoreboard bench for pisca_decoder: directed scenarios, a full lap-count wrap and random chaser traffic.
// An index-based reference model predicts each cycle's outputs. A monitor compares them after every edge.
module tb_pisca_decoder;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;

  pisca_decoder_if bus ();

  pisca_decoder dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  typedef enum {M_IDLE, M_TRACK, M_BLANK, M_FAULT} mode_t;

  typedef struct {
    int pos;
    bit valid;
    bit dir;
    bit frozen;
    bit restart;
    int lap;
    bit error;
    bit sticky;
    int seg;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  int   seg_tbl [8] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07};

  mode_t      m_mode   = M_IDLE;
  int         m_prev   = -1;
  int         m_pos    = 0;
  bit         m_dir    = 1'b0;
  int         m_lap    = 0;
  bit         m_sticky = 1'b0;
  logic [7:0] last_c   = 8'h00;

  // -1 = all dark, -2 = more than one LED lit, otherwise the lit LED's index.
  function automatic int idx_of(input logic [7:0] v);
    if (v == 8'h00) return -1;
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return -2;
  endfunction

  task automatic model_step(input bit rst, input logic [7:0] c, output exp_t e);
    int ci;
    ci = idx_of(c);
    e.valid = 1'b0; e.frozen = 1'b0; e.restart = 1'b0; e.error = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_prev = -1; m_pos = 0; m_dir = 1'b0; m_lap = 0; m_sticky = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_FAULT: begin
          if (ci >= 0) begin m_mode = M_TRACK; e.valid = 1'b1; m_pos = ci; end
          else if (ci == -2) begin m_mode = M_FAULT; e.error = 1'b1; end
        end
        M_TRACK: begin
          if (ci == m_prev) begin e.valid = 1'b1; e.frozen = 1'b1; m_pos = ci; end
          else if (ci >= 0 && ci == m_prev - 1) begin e.valid = 1'b1; m_pos = ci; m_dir = 1'b0; end
          else if (ci >= 0 && ci == m_prev + 1) begin e.valid = 1'b1; m_pos = ci; m_dir = 1'b1; end
          else if (ci == -1 && (m_prev == 0 || m_prev == 7)) m_mode = M_BLANK;
          else if (ci == 0 || ci == 7) begin
            e.valid = 1'b1; e.restart = 1'b1; m_pos = ci; m_dir = (ci == 0);
          end else begin m_mode = M_FAULT; e.error = 1'b1; end
        end
        default: begin
          if (ci == 0 || ci == 7) begin
            m_mode = M_TRACK; e.valid = 1'b1; m_pos = ci; m_dir = (ci == 0);
            m_lap = (m_lap + 1) % 256;
          end else if (ci != -1) begin m_mode = M_FAULT; e.error = 1'b1; end
        end
      endcase
      m_prev = ci;
      if (e.error) m_sticky = 1'b1;
    end
    e.pos = m_pos; e.dir = m_dir; e.lap = m_lap; e.sticky = m_sticky;
    if (e.valid)               e.seg = seg_tbl[m_pos];
    else if (m_mode == M_FAULT) e.seg = 'h79;
    else                        e.seg = 'h40;
    if (e.frozen) e.seg = e.seg | 'h80;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cycle, act, req);
    end
  endtask

  task automatic step(input bit rst, input logic [7:0] c);
    exp_t e;
    @(negedge clk_2);
    reset = rst;
    bus.pattern_in = c;
    model_step(rst, c, e);
    sb_q.push_back(e);
    last_c = c;
  endtask

  task automatic sweep_right();
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) begin
      v = 8'h01 << i;
      step(1'b0, v);
    end
  endtask

  // Monitor: one expectation is consumed per clock edge once stimulus has been issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2);
      #1;
      cycle++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pos",          {29'd0, bus.pos},       e.pos);
        check("valid",        {31'd0, bus.valid},     {31'd0, e.valid});
        check("dir",          {31'd0, bus.dir},       {31'd0, e.dir});
        check("frozen",       {31'd0, bus.frozen},    {31'd0, e.frozen});
        check("restart_evt",  {31'd0, bus.restart_evt}, {31'd0, e.restart});
        check("lap_count",    {24'd0, bus.lap_count}, e.lap);
        check("error",        {31'd0, bus.error},     {31'd0, e.error});
        check("error_sticky", {31'd0, bus.error_sticky}, {31'd0, e.sticky});
        check("SEG",          {24'd0, bus.SEG},       e.seg);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    bit         r;
    bus.pattern_in = 8'h00;

    step(1'b1, 8'h00); step(1'b1, 8'h5A);

    step(1'b0, 8'h80); step(1'b0, 8'h40); step(1'b0, 8'h20);
    step(1'b0, 8'h10); step(1'b0, 8'h08); step(1'b0, 8'h04);
    step(1'b0, 8'h02); step(1'b0, 8'h01); step(1'b0, 8'h00); step(1'b0, 8'h80);

    step(1'b1, 8'h00);
    step(1'b0, 8'h08); step(1'b0, 8'h08); step(1'b0, 8'h08); step(1'b0, 8'h10);
    step(1'b0, 8'h10); step(1'b0, 8'h01);

    step(1'b1, 8'h00);
    step(1'b0, 8'h10); step(1'b0, 8'h24); step(1'b0, 8'h02);

    step(1'b1, 8'h00);
    for (int n = 0; n < 256; n++) begin
      sweep_right();
      step(1'b0, 8'h00);
    end
    step(1'b0, 8'h80);

    step(1'b0, 8'h40); step(1'b0, 8'h20); step(1'b1, 8'h10); step(1'b0, 8'h80);

    for (int k = 0; k < 800; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    c = last_c >> 1;
        2, 3:    c = last_c << 1;
        4:       c = last_c;
        5:       c = 8'h00;
        6:       c = 8'h80;
        7:       c = 8'h01;
        8:       c = 8'($urandom);
        default: c = 8'h01 << $urandom_range(0, 7);
      endcase
      r = ($urandom_range(0, 49) == 0);
      step(r, c);
    end

    repeat (2) @(posedge clk_2);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
